// File: rtl/regfile_sb.sv
// regfile_sb: integer register file with a pending-write scoreboard.
//   - NREAD combinational read ports, one clocked writeback port.
//   - A per-register busy bit is set when decode issues a writer and cleared on writeback.
//     Decode uses it to stall on RAW (rd_busy_o) and WAW (iss_ready_o) hazards.
//   - Register 0 always reads as zero and is never busy.
//   - Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
//
// Issue handshake: an issue transfers in a cycle where both iss_valid_i and iss_ready_o
// are high. iss_ready_o depends only on the current busy state and the same-cycle
// writeback, never on iss_valid_i, so decode may look at it before it asserts valid.
module regfile_sb #(
  parameter int              XLEN     = 32,
  parameter int              NREGS    = 32,
  parameter int              NREAD    = 2,
  parameter int              SP_IDX   = 2,
  parameter logic [XLEN-1:0] SP_RESET = XLEN'('h7D7E0),
  parameter int              AW       = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr_i,
  output logic [NREAD*XLEN-1:0] rd_data_o,
  output logic [NREAD-1:0]      rd_busy_o,
  input  logic                  iss_valid_i,
  input  logic [AW-1:0]         iss_rd_i,
  output logic                  iss_ready_o,
  input  logic                  wb_valid_i,
  input  logic [AW-1:0]         wb_rd_i,
  input  logic [XLEN-1:0]       wb_data_i,
  output logic                  wb_err_o,
  output logic [AW:0]           busy_cnt_o
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic             wb_err_q, wb_err_d;

  logic wb_en;      // writeback that actually lands (x0 dropped)
  logic iss_set;    // accepted issue that marks a register busy
  logic set_new;    // set that turns a clear bit into a busy bit
  logic clr_eff;    // clear that turns a busy bit into a clear bit

  // Issue acceptance and scoreboard next state; on a same-rd issue+writeback the set wins.
  always_comb begin
    wb_en       = wb_valid_i && (wb_rd_i != '0);
    iss_ready_o = !busy_q[iss_rd_i] || (iss_rd_i == '0) ||
                  (wb_valid_i && (wb_rd_i == iss_rd_i));
    iss_set     = iss_valid_i && iss_ready_o && (iss_rd_i != '0);
    set_new     = iss_set && !busy_q[iss_rd_i];
    clr_eff     = wb_en && busy_q[wb_rd_i] && !(iss_set && (iss_rd_i == wb_rd_i));

    busy_d = busy_q;
    if (wb_en)   busy_d[wb_rd_i]  = 1'b0;
    if (iss_set) busy_d[iss_rd_i] = 1'b1;

    // The counter follows the real number of busy bits, so it can never run past NREGS-1.
    busy_cnt_d = busy_cnt_q;
    if (set_new && !clr_eff)      busy_cnt_d = busy_cnt_q + 1'b1;
    else if (clr_eff && !set_new) busy_cnt_d = busy_cnt_q - 1'b1;

    wb_err_d = wb_err_q || (wb_en && !busy_q[wb_rd_i]);
  end

  // Register array: reset contents, then the writeback port (x0 never written).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= (i == SP_IDX) ? SP_RESET : '0;
      end
    end else if (wb_en) begin
      regs_q[wb_rd_i] <= wb_data_i;
    end
  end

  // Scoreboard state: busy bits, busy count and the sticky writeback error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
      wb_err_q   <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      wb_err_q   <= wb_err_d;
    end
  end

  assign wb_err_o   = wb_err_q;
  assign busy_cnt_o = busy_cnt_q;

  // Combinational read ports, with optional write-through forwarding.
  always_comb begin
    rd_data_o = '0;
    rd_busy_o = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (rd_addr_i[k*AW +: AW] != '0) begin
        rd_data_o[k*XLEN +: XLEN] = regs_q[rd_addr_i[k*AW +: AW]];
        rd_busy_o[k]              = busy_q[rd_addr_i[k*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wb_valid_i && (wb_rd_i == rd_addr_i[k*AW +: AW])) begin
          rd_data_o[k*XLEN +: XLEN] = wb_data_i;
          rd_busy_o[k]              = 1'b0;
        end
`else
`endif
      end
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed bench for regfile_sb with default parameters
// (XLEN=32, NREGS=32, NREAD=2). Inputs change on the falling edge, outputs are
// sampled 1 ns later, well away from the rising edge.
module tb_regfile_sb;

  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int NREAD = 2;

  logic                  clk = 1'b0;
  logic                  clk_en = 1'b0;
  logic                  reset;
  logic [NREAD*AW-1:0]   rd_addr_i;
  logic [NREAD*XLEN-1:0] rd_data_o;
  logic [NREAD-1:0]      rd_busy_o;
  logic                  iss_valid_i;
  logic [AW-1:0]         iss_rd_i;
  logic                  iss_ready_o;
  logic                  wb_valid_i;
  logic [AW-1:0]         wb_rd_i;
  logic [XLEN-1:0]       wb_data_i;
  logic                  wb_err_o;
  logic [AW:0]           busy_cnt_o;

  int checks   = 0;
  int failures = 0;

  regfile_sb dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr_i   (rd_addr_i),
    .rd_data_o   (rd_data_o),
    .rd_busy_o   (rd_busy_o),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .iss_ready_o (iss_ready_o),
    .wb_valid_i  (wb_valid_i),
    .wb_rd_i     (wb_rd_i),
    .wb_data_i   (wb_data_i),
    .wb_err_o    (wb_err_o),
    .busy_cnt_o  (busy_cnt_o)
  );

  // Clock/reset block: clock is held low until the reset-only test is done.
  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks.
  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr_i = {a1, a0};
  endtask

  task automatic idle_inputs();
    iss_valid_i = 1'b0;
    iss_rd_i    = '0;
    wb_valid_i  = 1'b0;
    wb_rd_i     = '0;
    wb_data_i   = '0;
  endtask

  // Move to the next falling edge (inputs are driven right after it).
  task automatic next_cycle();
    @(negedge clk);
  endtask

  function automatic logic [XLEN-1:0] data0();
    return rd_data_o[0 +: XLEN];
  endfunction

  function automatic logic [XLEN-1:0] data1();
    return rd_data_o[XLEN +: XLEN];
  endfunction

  logic exp_bypass;

  initial begin
`ifdef REGFILE_BYPASS_EN
    exp_bypass = 1'b1;
`else
    exp_bypass = 1'b0;
`endif
    idle_inputs();
    set_rd(5'd2, 5'd0);
    iss_rd_i = 5'd5;

    // 1: reset with no clock running.
    reset = 1'b1;
    #2 reset = 1'b0;
    #2;
    check("t1_reg2",      64'(data0()), 64'h7D7E0);
    check("t1_reg0",      64'(data1()), 64'h0);
    check("t1_busy_cnt",  64'(busy_cnt_o), 64'd0);
    check("t1_iss_ready", 64'(iss_ready_o), 64'd1);
    check("t1_wb_err",    64'(wb_err_o), 64'd0);
    check("t1_rd_busy",   64'(rd_busy_o), 64'd0);
    for (int a = 1; a < 32; a++) begin
      if (a != 2) begin
        set_rd(5'(a), 5'(a));
        #1;
        check($sformatf("t1_reg%0d", a), 64'(rd_data_o), 64'h0);
      end
    end
    reset = 1'b1;
    #2 clk_en = 1'b1;
    iss_rd_i = '0;

    // 2: issue rd=5, then writeback rd=5 on the next cycle.
    next_cycle();
    iss_valid_i = 1'b1; iss_rd_i = 5'd5; set_rd(5'd5, 5'd2);
    #1 check("t2_iss_ready", 64'(iss_ready_o), 64'd1);
    next_cycle();
    idle_inputs();
    wb_valid_i = 1'b1; wb_rd_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    #1;
    check("t2_busy5_pending", 64'(rd_busy_o[0]), exp_bypass ? 64'd0 : 64'd1);
    check("t2_data5_pending", 64'(data0()), exp_bypass ? 64'hDEADBEEF : 64'h0);
    check("t2_cnt_pending",   64'(busy_cnt_o), 64'd1);
    next_cycle();
    idle_inputs();
    #1;
    check("t2_data5", 64'(data0()), 64'hDEADBEEF);
    check("t2_busy5", 64'(rd_busy_o[0]), 64'd0);
    check("t2_cnt",   64'(busy_cnt_o), 64'd0);
    check("t2_err",   64'(wb_err_o), 64'd0);

    // 3: WAW stall on rd=7, then issue with a same-cycle writeback to rd=7.
    iss_valid_i = 1'b1; iss_rd_i = 5'd7; set_rd(5'd7, 5'd0);
    next_cycle();
    #1 check("t3_iss_ready_stall", 64'(iss_ready_o), 64'd0);
    check("t3_cnt_busy", 64'(busy_cnt_o), 64'd1);
    next_cycle();
    #1 check("t3_cnt_after_stall", 64'(busy_cnt_o), 64'd1);
    wb_valid_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'h77;
    #1 check("t3_iss_ready_wb", 64'(iss_ready_o), 64'd1);
    next_cycle();
    idle_inputs();
    #1;
    check("t3_busy7_kept", 64'(rd_busy_o[0]), 64'd1);
    check("t3_data7",      64'(data0()), 64'h77);
    check("t3_cnt",        64'(busy_cnt_o), 64'd1);
    check("t3_err",        64'(wb_err_o), 64'd0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd7; wb_data_i = 32'h78;
    next_cycle();
    idle_inputs();
    #1 check("t3_cnt_drained", 64'(busy_cnt_o), 64'd0);
    check("t3_data7_final", 64'(data0()), 64'h78);

    // 4: writeback to x0 is dropped; writeback to a non-busy register is an error.
    wb_valid_i = 1'b1; wb_rd_i = 5'd0; wb_data_i = 32'h1234; set_rd(5'd0, 5'd9);
    next_cycle();
    idle_inputs();
    #1;
    check("t4_reg0", 64'(data0()), 64'h0);
    check("t4_err_x0", 64'(wb_err_o), 64'd0);
    check("t4_cnt_x0", 64'(busy_cnt_o), 64'd0);
    wb_valid_i = 1'b1; wb_rd_i = 5'd9; wb_data_i = 32'h99;
    next_cycle();
    idle_inputs();
    #1;
    check("t4_reg9", 64'(data1()), 64'h99);
    check("t4_err_set", 64'(wb_err_o), 64'd1);
    next_cycle();
    next_cycle();
    #1 check("t4_err_sticky", 64'(wb_err_o), 64'd1);

    // 5: read port 1 at rd=3 while rd=3 is written back in the same cycle.
    iss_valid_i = 1'b1; iss_rd_i = 5'd3; set_rd(5'd0, 5'd3);
    next_cycle();
    idle_inputs();
    wb_valid_i = 1'b1; wb_rd_i = 5'd3; wb_data_i = 32'hCAFE;
    #1;
    check("t5_data_fwd", 64'(data1()), exp_bypass ? 64'hCAFE : 64'h0);
    check("t5_busy_fwd", 64'(rd_busy_o[1]), exp_bypass ? 64'd0 : 64'd1);
    next_cycle();
    idle_inputs();
    #1;
    check("t5_data3", 64'(data1()), 64'hCAFE);
    check("t5_cnt",   64'(busy_cnt_o), 64'd0);

    // 6: three back-to-back issues, then reset before any writeback.
    iss_valid_i = 1'b1; iss_rd_i = 5'd4;
    next_cycle();
    iss_rd_i = 5'd6;
    next_cycle();
    iss_rd_i = 5'd8;
    next_cycle();
    idle_inputs();
    set_rd(5'd4, 5'd8);
    #1;
    check("t6_cnt3",   64'(busy_cnt_o), 64'd3);
    check("t6_busy48", 64'(rd_busy_o), 64'b11);
    #1 reset = 1'b0;
    #1;
    check("t6_cnt_rst",  64'(busy_cnt_o), 64'd0);
    check("t6_busy_rst", 64'(rd_busy_o), 64'b00);
    check("t6_err_rst",  64'(wb_err_o), 64'd0);
    set_rd(5'd2, 5'd5);
    #1;
    check("t6_reg2_rst", 64'(data0()), 64'h7D7E0);
    check("t6_reg5_rst", 64'(data1()), 64'h0);
    set_rd(5'd9, 5'd3);
    #1;
    check("t6_reg9_rst", 64'(data0()), 64'h0);
    check("t6_reg3_rst", 64'(data1()), 64'h0);
    next_cycle();
    reset = 1'b1;
    iss_rd_i = 5'd6;
    #1 check("t6_iss_ready_rst", 64'(iss_ready_o), 64'd1);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish, expected finish before 100000 ns");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
